// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the byte-serial memory arbiter: access-size
//   encodings, FSM state and owner encodings, the RAM byte width and a helper
//   that turns an access size into the index of its last byte.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Width of one RAM beat
    localparam int BYTE_W = 8;

    // MEM access size encodings (2'b11 behaves as a word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Current owner of the RAM port
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    // Index of the final byte of an access (byte count minus one)
    function automatic logic [1:0] size_last_idx(input logic [1:0] size);
        logic [1:0] last;
        case (size)
            SZ_BYTE: last = 2'd0;
            SZ_HALF: last = 2'd1;
            SZ_WORD: last = 2'd3;
            default: last = 2'd3;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-wide synchronous RAM port between the IF stage (32-bit
//   instruction fetch) and the MEM stage (byte/half/word load or store).
//   Each access is split into sequential byte cycles; read bytes are
//   reassembled little-endian and zero-extended.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   if_req/if_addr      IF fetch request (level) and byte address
//   if_rdata/if_done    fetched word and its one-cycle completion pulse
//   if_stallreq         if_req & ~if_done
//   mem_req/we/size/addr/wdata   MEM load/store request (level)
//   mem_rdata/mem_done  load data and its one-cycle completion pulse
//   mem_stallreq        mem_req & ~mem_done
//   ram_a/ram_dout/ram_wr  RAM address, write byte, write enable
//   ram_din             RAM read byte, valid the cycle after its address
//
// Timing (T = IDLE cycle in which the grant is taken):
//   read of N bytes completes in T+N+2, write of N bytes in T+N+1.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    output logic              if_stallreq,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_stallreq,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    // Transaction context latched at grant
    state_t              state_r;
    owner_t              owner_r;
    logic [1:0]          cnt_r;
    logic [1:0]          last_r;
    logic                we_r;
    logic [ADDR_W-1:0]   base_r;
    logic [31:0]         wdata_r;
    logic [31:0]         asm_r;

    // Grant candidate (MEM has priority over IF)
    logic                gnt_any_s;
    owner_t              gnt_owner_s;
    logic [ADDR_W-1:0]   gnt_addr_s;
    logic                gnt_we_s;
    logic [1:0]          gnt_last_s;
    logic [31:0]         gnt_wdata_s;

    // Per-beat datapath
    logic [1:0]          cnt_nxt_s;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [7:0]          wbyte_nxt_s;
    logic [1:0]          cap_idx_s;
    logic [31:0]         asm_cap_s;

    // Stall requests are purely combinational from request and done
    assign if_stallreq  = if_req  & ~if_done;
    assign mem_stallreq = mem_req & ~mem_done;

    // Select which requester would be granted this cycle
    always_comb begin
        gnt_any_s = mem_req | if_req;
        if (mem_req) begin
            gnt_owner_s = OWN_MEM;
            gnt_addr_s  = mem_addr;
            gnt_we_s    = mem_we;
            gnt_last_s  = size_last_idx(mem_size);
            gnt_wdata_s = mem_wdata;
        end else begin
            gnt_owner_s = OWN_IF;
            gnt_addr_s  = if_addr;
            gnt_we_s    = 1'b0;
            gnt_last_s  = 2'd3;
            gnt_wdata_s = 32'h0000_0000;
        end
    end

    // Next-beat address/write byte and read-byte capture into the assembler
    always_comb begin
        cnt_nxt_s   = cnt_r + 2'd1;
        // Address arithmetic wraps naturally modulo 2^ADDR_W
        addr_nxt_s  = base_r + ADDR_W'(cnt_nxt_s);
        wbyte_nxt_s = wdata_r[{cnt_nxt_s, 3'b000} +: BYTE_W];
        // RAM data lags its address by one cycle: in ISSUE the byte arriving
        // belongs to the previous beat, in DRAIN it is the current (last) one
        if (state_r == ST_DRAIN) begin
            cap_idx_s = cnt_r;
        end else begin
            cap_idx_s = cnt_r - 2'd1;
        end
        asm_cap_s = asm_r;
        asm_cap_s[{cap_idx_s, 3'b000} +: BYTE_W] = ram_din;
    end

    // Arbiter FSM with registered RAM-side and completion outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            owner_r   <= OWN_NONE;
            cnt_r     <= 2'd0;
            last_r    <= 2'd0;
            we_r      <= 1'b0;
            base_r    <= '0;
            wdata_r   <= 32'h0000_0000;
            asm_r     <= 32'h0000_0000;
            ram_a     <= '0;
            ram_dout  <= 8'h00;
            ram_wr    <= 1'b0;
            if_rdata  <= 32'h0000_0000;
            if_done   <= 1'b0;
            mem_rdata <= 32'h0000_0000;
            mem_done  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_any_s) begin
                        owner_r  <= gnt_owner_s;
                        base_r   <= gnt_addr_s;
                        we_r     <= gnt_we_s;
                        last_r   <= gnt_last_s;
                        wdata_r  <= gnt_wdata_s;
                        cnt_r    <= 2'd0;
                        asm_r    <= 32'h0000_0000;
                        // First beat is presented in the first ISSUE cycle
                        ram_a    <= gnt_addr_s;
                        ram_wr   <= gnt_we_s;
                        ram_dout <= gnt_wdata_s[7:0];
                        state_r  <= ST_ISSUE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    if (!we_r && (cnt_r != 2'd0)) begin
                        asm_r <= asm_cap_s;
                    end
                    if (cnt_r == last_r) begin
                        ram_wr <= 1'b0;
                        if (we_r) begin
                            state_r <= ST_DONE;
                            if (owner_r == OWN_MEM) begin
                                mem_done  <= 1'b1;
                                mem_rdata <= asm_r;
                            end else begin
                                if_done   <= 1'b1;
                                if_rdata  <= asm_r;
                            end
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end else begin
                        cnt_r    <= cnt_nxt_s;
                        ram_a    <= addr_nxt_s;
                        ram_dout <= wbyte_nxt_s;
                    end
                end

                ST_DRAIN: begin
                    asm_r   <= asm_cap_s;
                    state_r <= ST_DONE;
                    if (owner_r == OWN_MEM) begin
                        mem_done  <= 1'b1;
                        mem_rdata <= asm_cap_s;
                    end else begin
                        if_done   <= 1'b1;
                        if_rdata  <= asm_cap_s;
                    end
                end

                ST_DONE: begin
                    // Requests are deliberately not sampled here
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    owner_r  <= OWN_NONE;
                    state_r  <= ST_IDLE;
                end

                default: begin
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    ram_wr   <= 1'b0;
                    owner_r  <= OWN_NONE;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a small byte RAM model
//   (synchronous read, one-cycle latency). Inputs change 1 time unit after
//   a rising edge; outputs are sampled on the falling edge. Cycle index k=0
//   is the IDLE cycle in which the grant is taken.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              if_stallreq;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              mem_stallreq;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;

    int n_checks = 0;
    int n_fail   = 0;

    // RAM model (12-bit index) with a preload port so that it has one writer
    logic [7:0]  ram [0:4095];
    logic        pl_en;
    logic [11:0] pl_a;
    logic [7:0]  pl_d;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_a] <= pl_d;
        end else if (ram_wr) begin
            ram[ram_a[11:0]] <= ram_dout;
        end
        ram_din <= ram[ram_a[11:0]];
    end

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_done      (if_done),
        .if_stallreq  (if_stallreq),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .mem_stallreq (mem_stallreq),
        .ram_a        (ram_a),
        .ram_dout     (ram_dout),
        .ram_wr       (ram_wr),
        .ram_din      (ram_din)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case anything above stops advancing
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_a [0:3];
        int          wr_cnt;
        wrap_a[0] = 32'hFFFF_FFFE;
        wrap_a[1] = 32'hFFFF_FFFF;
        wrap_a[2] = 32'h0000_0000;
        wrap_a[3] = 32'h0000_0001;

        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
        mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0; pl_en = 1'b0;
        pl_a = 12'h000; pl_d = 8'h00;
        #1 rst = 1'b0;
        #11;
        // Reset state
        check_eq("rst ram_wr",    {31'd0, ram_wr},   32'h0);
        check_eq("rst ram_a",     ram_a,             32'h0);
        check_eq("rst if_done",   {31'd0, if_done},  32'h0);
        check_eq("rst mem_done",  {31'd0, mem_done}, 32'h0);
        check_eq("rst if_rdata",  if_rdata,          32'h0);
        check_eq("rst mem_rdata", mem_rdata,         32'h0);
        @(negedge clk);
        rst = 1'b1;

        preload(12'h100, 8'h13); preload(12'h101, 8'h05);
        preload(12'h102, 8'h10); preload(12'h103, 8'h00);
        preload(12'h200, 8'hFF);
        preload(12'h000, 8'h11); preload(12'h001, 8'h22);
        preload(12'h002, 8'h33); preload(12'h003, 8'h44);
        preload(12'hFFE, 8'hA1); preload(12'hFFF, 8'hB2);

        // IF word fetch at 0x100
        if_addr = 32'h100; if_req = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) check_eq("fetch ram_a", ram_a, 32'h100 + k - 1);
            check_eq("fetch stall", {31'd0, if_stallreq}, (k <= 5) ? 32'd1 : 32'd0);
            check_eq("fetch done",  {31'd0, if_done},     (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) begin
                check_eq("fetch rdata", if_rdata, 32'h0010_0513);
                drive_point();
                if_req = 1'b0;
            end
        end

        // Simultaneous IF and MEM byte load: MEM first, then IF
        drive_point();
        if_addr = 32'h0; if_req = 1'b1;
        mem_addr = 32'h200; mem_size = 2'b00; mem_we = 1'b0; mem_req = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("simul mem ram_a", ram_a, 32'h200);
            if (k == 2) check_eq("simul mem stall", {31'd0, mem_stallreq}, 32'd1);
            if (k == 5) check_eq("simul if ram_a0", ram_a, 32'h0);
            if (k == 8) check_eq("simul if ram_a3", ram_a, 32'h3);
            check_eq("simul mem_done", {31'd0, mem_done}, (k == 3) ? 32'd1 : 32'd0);
            check_eq("simul if_done",  {31'd0, if_done},  (k == 10) ? 32'd1 : 32'd0);
            if (k == 3) begin
                check_eq("simul mem_rdata", mem_rdata, 32'h0000_00FF);
                check_eq("simul if stall",  {31'd0, if_stallreq}, 32'd1);
                drive_point();
                mem_req = 1'b0;
            end
            if (k == 10) begin
                check_eq("simul if_rdata", if_rdata, 32'h4433_2211);
                drive_point();
                if_req = 1'b0;
            end
        end

        // Half store across 0x3FF/0x400
        drive_point();
        mem_we = 1'b1; mem_size = 2'b01; mem_addr = 32'h3FF; mem_wdata = 32'hAABB_CCDD;
        mem_req = 1'b1;
        wr_cnt = 0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (ram_wr) wr_cnt++;
            if (k == 1) begin
                check_eq("hst a0", ram_a, 32'h3FF);
                check_eq("hst d0", {24'd0, ram_dout}, 32'hDD);
            end
            if (k == 2) begin
                check_eq("hst a1", ram_a, 32'h400);
                check_eq("hst d1", {24'd0, ram_dout}, 32'hCC);
            end
            check_eq("hst done", {31'd0, mem_done}, (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) begin
                drive_point();
                mem_req = 1'b0; mem_we = 1'b0;
            end
        end
        check_eq("hst wr cycles", wr_cnt, 32'd2);
        check_eq("hst ram 3ff", {24'd0, ram[12'h3FF]}, 32'hDD);
        check_eq("hst ram 400", {24'd0, ram[12'h400]}, 32'hCC);

        // Half load back from 0x3FF: zero-extended, done at T+4
        drive_point();
        mem_size = 2'b01; mem_addr = 32'h3FF; mem_req = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check_eq("hld done", {31'd0, mem_done}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) begin
                check_eq("hld rdata", mem_rdata, 32'h0000_CCDD);
                drive_point();
                mem_req = 1'b0;
            end
        end

        // IF request withdrawn two cycles into a fetch
        drive_point();
        if_addr = 32'h100; if_req = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 1) check_eq("wd stall hi", {31'd0, if_stallreq}, 32'd1);
            else        check_eq("wd stall lo", {31'd0, if_stallreq}, 32'd0);
            check_eq("wd done", {31'd0, if_done}, (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) check_eq("wd rdata", if_rdata, 32'h0010_0513);
            if (k == 1) begin
                drive_point();
                if_req = 1'b0;
            end
        end

        // Reset during the third ISSUE cycle of a word store
        drive_point();
        mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h500; mem_wdata = 32'h0102_0304;
        mem_req = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("rmid d0", {24'd0, ram_dout}, 32'h04);
            if (k == 3) begin
                check_eq("rmid wr before", {31'd0, ram_wr}, 32'd1);
                check_eq("rmid a2", ram_a, 32'h502);
            end
        end
        #1 rst = 1'b0;
        #1;
        check_eq("rmid wr async",   {31'd0, ram_wr}, 32'd0);
        check_eq("rmid ram_a",      ram_a, 32'h0);
        check_eq("rmid ram_dout",   {24'd0, ram_dout}, 32'h0);
        check_eq("rmid mem_rdata",  mem_rdata, 32'h0);
        check_eq("rmid if_rdata",   if_rdata, 32'h0);
        mem_req = 1'b0; mem_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("rmid no done", {31'd0, mem_done | if_done}, 32'd0);
        end
        check_eq("rmid ram 501", {24'd0, ram[12'h501]}, 32'h03);
        drive_point();
        if_addr = 32'h100; if_req = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) check_eq("post rst ram_a", ram_a, 32'h100);
            check_eq("post rst done", {31'd0, if_done}, (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) begin
                check_eq("post rst rdata", if_rdata, 32'h0010_0513);
                drive_point();
                if_req = 1'b0;
            end
        end

        // Word load wrapping past the top of the address space
        drive_point();
        mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'hFFFF_FFFE; mem_req = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) check_eq("wrap ram_a", ram_a, wrap_a[k-1]);
            check_eq("wrap done", {31'd0, mem_done}, (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) begin
                check_eq("wrap rdata", mem_rdata, 32'h2211_B2A1);
                drive_point();
                mem_req = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
